scarv_cop_issue_ctrl: RTL and testbench

- Sequences one decoded ISE instruction at a time through the coprocessor, between the CPU instruction interface and the functional units (FUs).
- Consumes the decoder's class, exception and init outputs and raises a one-hot request to the matching FU. It then waits for completion, writes results back to the CPR file (two sequential writes for multi-precision results) and returns a status response to the CPU.
- Also runs the CPR-clear sequence for the init instruction.

---
 rtl/scarv_cop_issue_ctrl_if.sv | 48 ++++
 rtl/scarv_cop_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_scarv_cop_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_issue_ctrl_if.sv
// Handshake and data bundle between the issue controller, the CPU
// instruction port, the functional units and the CPR file.
interface scarv_cop_issue_ctrl_if;
  // CPU instruction request and decoder outputs
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [8:0]  id_class;
  logic        id_exception;
  logic        id_cprs_init;
  logic        id_mp_dual;
  logic [3:0]  id_crd;
  logic [3:0]  id_crd1;
  logic [3:0]  id_crd2;
  // Functional units
  logic [8:0]  fu_req;
  logic [8:0]  fu_done;
  logic        fu_wen;
  logic        fu_error;
  logic [31:0] fu_wdata_lo;
  logic [31:0] fu_wdata_hi;
  // CPR write port
  logic        cprs_wen;
  logic [3:0]  cprs_waddr;
  logic [31:0] cprs_wdata;
  // CPU response
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready;
  logic [1:0]  cpu_rsp_status;
  logic        busy;

  // Controller side
  modport master (
    input  cpu_insn_req, id_class, id_exception, id_cprs_init, id_mp_dual,
           id_crd, id_crd1, id_crd2, fu_done, fu_wen, fu_error, fu_wdata_lo,
           fu_wdata_hi, cpu_rsp_ready,
    output cpu_insn_ack, fu_req, cprs_wen, cprs_waddr, cprs_wdata,
           cpu_rsp_valid, cpu_rsp_status, busy
  );

  // CPU / FU / CPR side
  modport slave (
    output cpu_insn_req, id_class, id_exception, id_cprs_init, id_mp_dual,
           id_crd, id_crd1, id_crd2, fu_done, fu_wen, fu_error, fu_wdata_lo,
           fu_wdata_hi, cpu_rsp_ready,
    input  cpu_insn_ack, fu_req, cprs_wen, cprs_waddr, cprs_wdata,
           cpu_rsp_valid, cpu_rsp_status, busy
  );
endinterface

// File: rtl/scarv_cop_issue_ctrl.sv
// Coprocessor issue controller: accepts one decoded instruction, dispatches
// it to a functional unit, writes results back to the CPR file and returns
// a status response to the CPU. Also runs the CPR-clear sequence for init.
module scarv_cop_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned NUM_CPRS       = 16
) (
  input  logic                          g_clk,
  input  logic                          g_resetn,
  scarv_cop_issue_ctrl_if.master        bus
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] RspOk      = 2'd0;
  localparam logic [1:0] RspIllegal = 2'd1;
  localparam logic [1:0] RspFuErr   = 2'd2;
  localparam logic [1:0] RspTimeout = 2'd3;

  typedef enum logic [2:0] {StIdle, StDispatch, StWb1, StWb2, StInit, StResp} state_e;

  state_e              state_q, state_d;
  logic [8:0]          class_q, class_d;
  logic [3:0]          crd_q, crd_d, crd1_q, crd1_d, crd2_q, crd2_d;
  logic                mp_q, mp_d;
  logic [31:0]         lo_q, lo_d, hi_q, hi_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [3:0]          init_cnt_q, init_cnt_d;
  logic [1:0]          status_q, status_d;

  logic                illegal;
  logic                done_sel;

  // Init with no class bits set is a legal encoding.
  assign illegal  = bus.id_exception |
                    (!$onehot(bus.id_class) && !(bus.id_cprs_init && bus.id_class == 9'd0));
  // Only the selected FU's done matters.
  assign done_sel = |(bus.fu_done & class_q);

  // State and datapath registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= StIdle;
      class_q    <= '0;
      crd_q      <= '0;
      crd1_q     <= '0;
      crd2_q     <= '0;
      mp_q       <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      timer_q    <= '0;
      init_cnt_q <= '0;
      status_q   <= RspOk;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      crd_q      <= crd_d;
      crd1_q     <= crd1_d;
      crd2_q     <= crd2_d;
      mp_q       <= mp_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      timer_q    <= timer_d;
      init_cnt_q <= init_cnt_d;
      status_q   <= status_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d            = state_q;
    class_d            = class_q;
    crd_d              = crd_q;
    crd1_d             = crd1_q;
    crd2_d             = crd2_q;
    mp_d               = mp_q;
    lo_d               = lo_q;
    hi_d               = hi_q;
    timer_d            = timer_q;
    init_cnt_d         = init_cnt_q;
    status_d           = status_q;
    bus.cpu_insn_ack   = 1'b0;
    bus.fu_req         = '0;
    bus.cprs_wen       = 1'b0;
    bus.cprs_waddr     = '0;
    bus.cprs_wdata     = '0;
    bus.cpu_rsp_valid  = 1'b0;
    bus.cpu_rsp_status = RspOk;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_insn_req) begin
          // Gated so the ack is silent while reset is held.
          bus.cpu_insn_ack = g_resetn;
          class_d          = bus.id_class;
          crd_d            = bus.id_crd;
          crd1_d           = bus.id_crd1;
          crd2_d           = bus.id_crd2;
          mp_d             = bus.id_mp_dual;
          timer_d          = '0;
          init_cnt_d       = '0;
          if (illegal) begin
            status_d = RspIllegal;
            state_d  = StResp;
          end else if (bus.id_cprs_init) begin
            state_d  = StInit;
          end else begin
            state_d  = StDispatch;
          end
        end
      end
      StDispatch: begin
        bus.fu_req = class_q;
        // Done takes priority over a coincident timeout.
        if (done_sel) begin
          lo_d = bus.fu_wdata_lo;
          hi_d = bus.fu_wdata_hi;
          if (bus.fu_error) begin
            status_d = RspFuErr;
            state_d  = StResp;
          end else if (!bus.fu_wen) begin
            status_d = RspOk;
            state_d  = StResp;
          end else begin
            state_d  = StWb1;
          end
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          status_d = RspTimeout;
          state_d  = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWb1: begin
        bus.cprs_wen   = 1'b1;
        bus.cprs_waddr = mp_q ? crd1_q : crd_q;
        bus.cprs_wdata = lo_q;
        if (mp_q) begin
          state_d = StWb2;
        end else begin
          status_d = RspOk;
          state_d  = StResp;
        end
      end
      StWb2: begin
        bus.cprs_wen   = 1'b1;
        bus.cprs_waddr = crd2_q;
        bus.cprs_wdata = hi_q;
        status_d       = RspOk;
        state_d        = StResp;
      end
      StInit: begin
        bus.cprs_wen   = 1'b1;
        bus.cprs_waddr = init_cnt_q;
        bus.cprs_wdata = '0;
        if (init_cnt_q == 4'(NUM_CPRS - 1)) begin
          status_d = RspOk;
          state_d  = StResp;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StResp: begin
        bus.cpu_rsp_valid  = 1'b1;
        bus.cpu_rsp_status = status_q;
        if (bus.cpu_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy = (state_q != StIdle);

endmodule

// File: tb/tb_scarv_cop_issue_ctrl.sv
// Directed bench for the coprocessor issue controller.
module tb_scarv_cop_issue_ctrl;

  logic g_clk;
  logic g_resetn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  scarv_cop_issue_ctrl_if bus ();

  scarv_cop_issue_ctrl #(
    .TIMEOUT_CYCLES (255),
    .NUM_CPRS       (16)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  // Record CPR writes and FU request cycles away from the active edge.
  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          fu_req_cyc = 0;
  always @(negedge g_clk) begin
    if (bus.cprs_wen === 1'b1) begin
      wr_addr.push_back(bus.cprs_waddr);
      wr_data.push_back(bus.cprs_wdata);
    end
    if (bus.fu_req !== 9'd0) fu_req_cyc++;
  end

  task automatic cyc();
    @(posedge g_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one instruction in IDLE, expect the same-cycle ack.
  task automatic issue(input logic [8:0] cls, input logic exc, input logic init,
                       input logic mp, input logic [3:0] crd, input logic [3:0] crd1,
                       input logic [3:0] crd2, input string tag);
    bus.cpu_insn_req = 1'b1;
    bus.id_class     = cls;
    bus.id_exception = exc;
    bus.id_cprs_init = init;
    bus.id_mp_dual   = mp;
    bus.id_crd       = crd;
    bus.id_crd1      = crd1;
    bus.id_crd2      = crd2;
    #1;
    chk({tag, "_ack"}, bus.cpu_insn_ack, 1);
    cyc();
    bus.cpu_insn_req = 1'b0;
    bus.id_class     = '0;
    bus.id_exception = 1'b0;
    bus.id_cprs_init = 1'b0;
    bus.id_mp_dual   = 1'b0;
    bus.id_crd       = '0;
    bus.id_crd1      = '0;
    bus.id_crd2      = '0;
  endtask

  // Wait (bounded) for a response, check status, complete the handshake.
  task automatic wait_rsp(input logic [1:0] exp_status, input string tag, output int n);
    n = 0;
    while (bus.cpu_rsp_valid !== 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    chk({tag, "_rsp_valid"}, bus.cpu_rsp_valid, 1);
    chk({tag, "_rsp_status"}, bus.cpu_rsp_status, exp_status);
    chk({tag, "_rsp_nowen"}, bus.cprs_wen, 0);
    bus.cpu_rsp_ready = 1'b1;
    cyc();
    bus.cpu_rsp_ready = 1'b0;
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic fu_set(input logic [8:0] done, input logic wen, input logic err,
                        input logic [31:0] lo, input logic [31:0] hi);
    bus.fu_done     = done;
    bus.fu_wen      = wen;
    bus.fu_error    = err;
    bus.fu_wdata_lo = lo;
    bus.fu_wdata_hi = hi;
  endtask

  int n;
  int w0;
  int f0;

  initial begin
    g_resetn          = 1'b0;
    bus.cpu_insn_req  = 1'b0;
    bus.id_class      = '0;
    bus.id_exception  = 1'b0;
    bus.id_cprs_init  = 1'b0;
    bus.id_mp_dual    = 1'b0;
    bus.id_crd        = '0;
    bus.id_crd1       = '0;
    bus.id_crd2       = '0;
    bus.cpu_rsp_ready = 1'b0;
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    cyc();
    g_resetn = 1'b1;
    cyc();

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_fu_req", bus.fu_req, 0);
    chk("rst_wen", bus.cprs_wen, 0);
    chk("rst_rsp_valid", bus.cpu_rsp_valid, 0);
    chk("rst_ack", bus.cpu_insn_ack, 0);

    // Single write, done in the 3rd dispatch cycle, stray done from another FU
    w0 = wr_addr.size();
    f0 = fu_req_cyc;
    issue(9'b000000100, 1'b0, 1'b0, 1'b0, 4'd5, 4'd9, 4'd10, "sw");
    chk("sw_fu_req", bus.fu_req, 9'b000000100);
    chk("sw_busy", bus.busy, 1);
    chk("sw_no_ack", bus.cpu_insn_ack, 0);
    fu_set(9'b000000001, 1'b1, 1'b0, 32'h11111111, 32'h0);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("sw_fu_req_hold", bus.fu_req, 9'b000000100);
    cyc();
    fu_set(9'b000000100, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("sw_wb_wen", bus.cprs_wen, 1);
    chk("sw_wb_addr", bus.cprs_waddr, 5);
    chk("sw_wb_data", bus.cprs_wdata, 32'hDEADBEEF);
    chk("sw_wb_fu_req", bus.fu_req, 0);
    wait_rsp(2'd0, "sw", n);
    chk("sw_wb_to_rsp", n, 1);
    chk("sw_nwrites", wr_addr.size() - w0, 1);
    chk("sw_fu_req_cycles", fu_req_cyc - f0, 3);

    // Multi-precision pair write, done in the first dispatch cycle
    w0 = wr_addr.size();
    issue(9'b000001000, 1'b0, 1'b0, 1'b1, 4'd3, 4'd6, 4'd7, "mp");
    fu_set(9'b000001000, 1'b1, 1'b0, 32'h1, 32'h2);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("mp_wb1_addr", bus.cprs_waddr, 6);
    chk("mp_wb1_data", bus.cprs_wdata, 1);
    cyc();
    chk("mp_wb2_wen", bus.cprs_wen, 1);
    chk("mp_wb2_addr", bus.cprs_waddr, 7);
    chk("mp_wb2_data", bus.cprs_wdata, 2);
    wait_rsp(2'd0, "mp", n);
    chk("mp_nwrites", wr_addr.size() - w0, 2);

    // FU error: status 2, no write
    w0 = wr_addr.size();
    issue(9'b000010000, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, "err");
    fu_set(9'b000010000, 1'b1, 1'b1, 32'hCAFE, 32'h0);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(2'd2, "err", n);
    chk("err_lat", n, 0);
    chk("err_nwrites", wr_addr.size() - w0, 0);

    // FU done without write-back: status 0, no write
    w0 = wr_addr.size();
    issue(9'b000100000, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, "nowen");
    fu_set(9'b000100000, 1'b0, 1'b0, 32'hBEEF, 32'h0);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(2'd0, "nowen", n);
    chk("nowen_nwrites", wr_addr.size() - w0, 0);

    // Illegal instructions: exception, two-hot class, empty class without init
    w0 = wr_addr.size();
    f0 = fu_req_cyc;
    issue(9'b000000100, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, "ill_exc");
    chk("ill_exc_fu_req", bus.fu_req, 0);
    wait_rsp(2'd1, "ill_exc", n);
    issue(9'b000000011, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, "ill_cls");
    wait_rsp(2'd1, "ill_cls", n);
    issue(9'b000000000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, "ill_zero");
    wait_rsp(2'd1, "ill_zero", n);
    chk("ill_nwrites", wr_addr.size() - w0, 0);
    chk("ill_fu_req_cycles", fu_req_cyc - f0, 0);

    // Init: 16 writes of zero to 0..15
    w0 = wr_addr.size();
    issue(9'b000000000, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, "init");
    wait_rsp(2'd0, "init", n);
    chk("init_cycles", n, 16);
    chk("init_nwrites", wr_addr.size() - w0, 16);
    for (int i = 0; i < 16; i++) begin
      if (w0 + i < wr_addr.size()) begin
        chk($sformatf("init_addr%0d", i), wr_addr[w0+i], i);
        chk($sformatf("init_data%0d", i), wr_data[w0+i], 0);
      end
    end

    // Timeout: no done at all
    w0 = wr_addr.size();
    f0 = fu_req_cyc;
    issue(9'b100000000, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, "tmo");
    wait_rsp(2'd3, "tmo", n);
    chk("tmo_cycles", n, 255);
    chk("tmo_fu_req_cycles", fu_req_cyc - f0, 255);
    chk("tmo_nwrites", wr_addr.size() - w0, 0);

    // Done on the last cycle before timeout wins
    w0 = wr_addr.size();
    f0 = fu_req_cyc;
    issue(9'b010000000, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, "late");
    repeat (254) cyc();
    chk("late_fu_req", bus.fu_req, 9'b010000000);
    fu_set(9'b010000000, 1'b1, 1'b0, 32'h55, 32'h0);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("late_wb_wen", bus.cprs_wen, 1);
    chk("late_wb_addr", bus.cprs_waddr, 3);
    chk("late_wb_data", bus.cprs_wdata, 32'h55);
    wait_rsp(2'd0, "late", n);
    chk("late_fu_req_cycles", fu_req_cyc - f0, 255);

    // Backpressure with a new request pending
    issue(9'b000000011, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, "bp");
    bus.cpu_insn_req = 1'b1;
    bus.id_class     = 9'b000000001;
    bus.id_crd       = 4'd8;
    repeat (10) begin
      #1;
      chk("bp_valid", bus.cpu_rsp_valid, 1);
      chk("bp_status", bus.cpu_rsp_status, 1);
      chk("bp_no_ack", bus.cpu_insn_ack, 0);
      cyc();
    end
    bus.cpu_rsp_ready = 1'b1;
    #1;
    chk("bp_hs_no_ack", bus.cpu_insn_ack, 0);
    cyc();
    bus.cpu_rsp_ready = 1'b0;
    #1;
    chk("bp_after_idle", bus.busy, 0);
    chk("bp_after_ack", bus.cpu_insn_ack, 1);
    cyc();
    bus.cpu_insn_req = 1'b0;
    bus.id_class     = '0;
    bus.id_crd       = '0;
    fu_set(9'b000000001, 1'b1, 1'b0, 32'hA5, 32'h0);
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("bp_wb_addr", bus.cprs_waddr, 8);
    chk("bp_wb_data", bus.cprs_wdata, 32'hA5);
    wait_rsp(2'd0, "bp2", n);

    // Reset during dispatch
    w0 = wr_addr.size();
    issue(9'b000000010, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, "rst_mid");
    cyc();
    g_resetn = 1'b0;
    bus.cpu_insn_req = 1'b1;
    bus.id_class     = 9'b000000010;
    #1;
    chk("rstm_busy", bus.busy, 0);
    chk("rstm_fu_req", bus.fu_req, 0);
    chk("rstm_wen", bus.cprs_wen, 0);
    chk("rstm_valid", bus.cpu_rsp_valid, 0);
    chk("rstm_ack", bus.cpu_insn_ack, 0);
    bus.cpu_insn_req = 1'b0;
    bus.id_class     = '0;
    fu_set(9'b000000010, 1'b1, 1'b0, 32'h77, 32'h0);
    cyc();
    cyc();
    fu_set(9'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    g_resetn = 1'b1;
    repeat (5) cyc();
    chk("rstm_nwrites", wr_addr.size() - w0, 0);
    chk("rstm_post_valid", bus.cpu_rsp_valid, 0);
    chk("rstm_post_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
